dht_reader: RTL and testbench

- Parametrised single-wire DHT11/DHT22 sensor reader; successor to the fixed-timing DHT front-end on the board.
- Issues the host start pulse, times the sensor handshake and 40 data bits, verifies the checksum, and presents humidity/temperature to downstream logic such as the display driver.
- Adds what the previous front-end lacked: configurable clock rate and timings, per-phase timeouts, checksum check and error reporting.

---
 rtl/dht_reader.sv | 168 ++++++++++++++++
 tb/tb_dht_reader.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/dht_reader.sv
// DHT11/DHT22 single-wire reader: host start pulse, handshake timing, 40-bit capture, checksum.
// Optional macro DHT_SYNC_EN inserts a 2-flop synchroniser on dht_in.
module dht_reader #(
    parameter int TICK_DIV      = 1,
    parameter int START_LOW_US  = 18000,
    parameter int BIT_THRESH_US = 40,
    parameter int TIMEOUT_US    = 200,
    parameter int CNT_W         = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        dht_in,
    output logic        dht_oe,
    output logic        busy,
    output logic        valid,
    output logic        err,
    output logic [1:0]  err_code,
    output logic [15:0] humidity,
    output logic [15:0] temperature,
    output logic [39:0] raw
);
    localparam int               PRE_W        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST     = PRE_W'(TICK_DIV - 1);
    localparam logic [CNT_W-1:0] START_LAST   = CNT_W'(START_LOW_US - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_US - 1);
    localparam logic [CNT_W-1:0] THRESH       = CNT_W'(BIT_THRESH_US);

    typedef enum logic [2:0] {
        IDLE, START_LOW, RELEASE, RESP_LOW, RESP_HIGH, BIT_LOW, BIT_HIGH, CHECK
    } state_t;

    state_t             state_r, next_state_s;
    logic [PRE_W-1:0]   pre_r;
    logic [CNT_W-1:0]   cnt_r;
    logic [5:0]         bit_idx_r;
    logic [39:0]        shift_r;
    logic               dht_s, tick_s, start_ok_s, wait_exp_s, timeout_s, state_chg_s, sum_ok_s;
    logic               dht_oe_r, busy_r, valid_r, err_r;
    logic [1:0]         err_code_r;
    logic [39:0]        raw_r;

    // Modular byte sum over humidity and temperature bytes of a frame.
    function automatic logic [7:0] frame_sum(input logic [39:0] f);
        frame_sum = f[39:32] + f[31:24] + f[23:16] + f[15:8];
    endfunction

`ifdef DHT_SYNC_EN
    logic [1:0] sync_r;
    // Synchroniser idles high to match the pulled-up line.
    always_ff @(posedge clk) begin
        if (rst) sync_r <= 2'b11;
        else     sync_r <= {sync_r[0], dht_in};
    end
    assign dht_s = sync_r[1];
`else
    assign dht_s = dht_in;
`endif

    assign tick_s      = (pre_r == PRE_LAST);
    assign wait_exp_s  = tick_s && (cnt_r == TIMEOUT_LAST);
    // A start coinciding with the valid/err pulse is dropped: the frame is not yet closed.
    assign start_ok_s  = start && (state_r == IDLE) && !valid_r && !err_r;
    assign state_chg_s = (next_state_s != state_r);
    assign sum_ok_s    = (frame_sum(shift_r) == shift_r[7:0]);

    // Next-state logic; a level change wins over a timeout in the same cycle.
    always_comb begin
        next_state_s = state_r;
        timeout_s    = 1'b0;
        case (state_r)
            IDLE: begin
                if (start_ok_s) next_state_s = START_LOW;
                else            next_state_s = IDLE;
            end
            START_LOW: begin
                if (tick_s && (cnt_r == START_LAST)) next_state_s = RELEASE;
                else                                 next_state_s = START_LOW;
            end
            RELEASE, RESP_HIGH: begin
                if (!dht_s)          next_state_s = (state_r == RELEASE) ? RESP_LOW : BIT_LOW;
                else if (wait_exp_s) begin next_state_s = IDLE; timeout_s = 1'b1; end
                else                 next_state_s = state_r;
            end
            RESP_LOW, BIT_LOW: begin
                if (dht_s)           next_state_s = (state_r == RESP_LOW) ? RESP_HIGH : BIT_HIGH;
                else if (wait_exp_s) begin next_state_s = IDLE; timeout_s = 1'b1; end
                else                 next_state_s = state_r;
            end
            BIT_HIGH: begin
                if (!dht_s)          next_state_s = (bit_idx_r == 6'd39) ? CHECK : BIT_LOW;
                else if (wait_exp_s) begin next_state_s = IDLE; timeout_s = 1'b1; end
                else                 next_state_s = BIT_HIGH;
            end
            CHECK:   next_state_s = IDLE;
            default: next_state_s = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_r <= IDLE;
        else     state_r <= next_state_s;
    end

    // Prescaler and us counter both restart on a state change so every phase is timed from zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            pre_r <= '0;
            cnt_r <= '0;
        end else begin
            if (state_chg_s || tick_s) pre_r <= '0;
            else                       pre_r <= pre_r + PRE_W'(1);
            if (state_chg_s || (state_r == IDLE)) cnt_r <= '0;
            else if (tick_s)                      cnt_r <= cnt_r + CNT_W'(1);
            else                                  cnt_r <= cnt_r;
        end
    end

    // Bit capture: high-phase length decides the bit value, shifted in MSB first.
    always_ff @(posedge clk) begin
        if (rst) begin
            bit_idx_r <= 6'd0;
            shift_r   <= 40'd0;
        end else if ((state_r == RESP_HIGH) && !dht_s) begin
            bit_idx_r <= 6'd0;
            shift_r   <= shift_r;
        end else if ((state_r == BIT_HIGH) && !dht_s) begin
            bit_idx_r <= bit_idx_r + 6'd1;
            shift_r   <= {shift_r[38:0], (cnt_r > THRESH)};
        end else begin
            bit_idx_r <= bit_idx_r;
            shift_r   <= shift_r;
        end
    end

    // Registered outputs; data registers move only on a good checksum.
    always_ff @(posedge clk) begin
        if (rst) begin
            dht_oe_r   <= 1'b0;
            busy_r     <= 1'b0;
            valid_r    <= 1'b0;
            err_r      <= 1'b0;
            err_code_r <= 2'b00;
            raw_r      <= 40'd0;
        end else begin
            dht_oe_r <= (next_state_s == START_LOW);
            busy_r   <= (next_state_s != IDLE);
            valid_r  <= (state_r == CHECK) && sum_ok_s;
            err_r    <= timeout_s || ((state_r == CHECK) && !sum_ok_s);
            if (start_ok_s)                          err_code_r <= 2'b00;
            else if (timeout_s)                      err_code_r <= 2'b01;
            else if ((state_r == CHECK) && !sum_ok_s) err_code_r <= 2'b10;
            else                                     err_code_r <= err_code_r;
            if ((state_r == CHECK) && sum_ok_s) raw_r <= shift_r;
            else                                raw_r <= raw_r;
        end
    end

    assign dht_oe      = dht_oe_r;
    assign busy        = busy_r;
    assign valid       = valid_r;
    assign err         = err_r;
    assign err_code    = err_code_r;
    assign raw         = raw_r;
    assign humidity    = raw_r[39:24];
    assign temperature = raw_r[23:8];
endmodule

// File: tb/tb_dht_reader.sv
// Directed self-checking bench for dht_reader with a cycle-accurate sensor model (1 cycle = 1 us).
module tb_dht_reader;
    logic        clk = 1'b0, rst = 1'b1, start = 1'b0, dht_in = 1'b1;
    logic        dht_oe, busy, valid, err;
    logic [1:0]  err_code;
    logic [15:0] humidity, temperature;
    logic [39:0] raw;

    int n_checks = 0, n_pass = 0, n_fail = 0;
    int cyc = 0, valid_cnt = 0, err_cnt = 0, valid_cyc = 0;
    int n_hi, rel_cyc, fall_cyc, err_cyc;
    bit found;

`ifdef DHT_SYNC_EN
    localparam int VLAT = 4;
`else
    localparam int VLAT = 2;
`endif
    localparam logic [39:0] F_GOOD = 40'h35_00_18_00_4D;
    localparam logic [39:0] F_BAD  = 40'h35_00_18_00_4E;
    localparam logic [39:0] F_ALT  = 40'h02_72_00_FA_6E;

    dht_reader #(.TICK_DIV(1), .START_LOW_US(100), .BIT_THRESH_US(40),
                 .TIMEOUT_US(200), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .start(start), .dht_in(dht_in), .dht_oe(dht_oe),
        .busy(busy), .valid(valid), .err(err), .err_code(err_code),
        .humidity(humidity), .temperature(temperature), .raw(raw)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) begin
        if (valid === 1'b1) begin valid_cnt++; valid_cyc = cyc; end
        if (err === 1'b1) err_cnt++;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic hold(input logic lvl, input int n);
        dht_in = lvl;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Counts negedges with dht_oe high until it drops; rel = cycle number at release.
    task automatic measure_oe(output int hi, output int rel);
        bit done;
        done = 1'b0; hi = 0; rel = 0;
        for (int i = 0; i < 2000 && !done; i++) begin
            @(negedge clk);
            if (dht_oe === 1'b1) hi++;
            else if (hi > 0) begin done = 1'b1; rel = cyc; end
        end
        check("oe_release_seen", 64'(done), 64'd1);
    endtask

    // Sensor response plus the first nbits data bits; optional start pulse inside one bit-high.
    task automatic send_bits(input logic [39:0] f, input int nbits, input int start_bit);
        hold(1'b1, 20);
        hold(1'b0, 80);
        hold(1'b1, 80);
        for (int i = 0; i < nbits; i++) begin
            hold(1'b0, 50);
            if (i == start_bit) begin
                dht_in = 1'b1;
                do_start();
                hold(1'b1, f[39-i] ? 69 : 25);
            end else begin
                hold(1'b1, f[39-i] ? 70 : 26);
            end
        end
    endtask

    task automatic finish_frame(output int fall);
        fall = cyc;
        hold(1'b0, 50);
        dht_in = 1'b1;
    endtask

    task automatic wait_err(input int limit, output bit seen, output int at);
        seen = 1'b0; at = 0;
        for (int i = 0; i < limit && !seen; i++) begin
            @(negedge clk);
            if (err === 1'b1) begin seen = 1'b1; at = cyc; end
        end
    endtask

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_oe", 64'(dht_oe), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_pulses", 64'({valid, err, err_code}), 64'd0);
        check("rst_raw", 64'(raw), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (2) @(posedge clk); #1;

        // Good frame
        do_start();
        measure_oe(n_hi, rel_cyc);
        check("start_low_len", 64'(n_hi), 64'd100);
        send_bits(F_GOOD, 40, -1);
        finish_frame(fall_cyc);
        check("good_valid_cnt", 64'(valid_cnt), 64'd1);
        check("good_valid_lat", 64'(valid_cyc - fall_cyc), 64'(VLAT));
        check("good_hum", 64'(humidity), 64'h3500);
        check("good_temp", 64'(temperature), 64'h1800);
        check("good_raw", 64'(raw), 64'h35_0018_004D);
        check("good_busy", 64'(busy), 64'd0);
        check("good_errcnt", 64'(err_cnt), 64'd0);
        check("good_errcode", 64'(err_code), 64'd0);

        // Bad checksum
        do_start();
        measure_oe(n_hi, rel_cyc);
        send_bits(F_BAD, 40, -1);
        finish_frame(fall_cyc);
        check("bad_errcnt", 64'(err_cnt), 64'd1);
        check("bad_validcnt", 64'(valid_cnt), 64'd1);
        check("bad_errcode", 64'(err_code), 64'd2);
        check("bad_hum_kept", 64'(humidity), 64'h3500);
        check("bad_temp_kept", 64'(temperature), 64'h1800);

        // No response after release; a start during the err pulse is dropped
        do_start();
        measure_oe(n_hi, rel_cyc);
        wait_err(400, found, err_cyc);
        check("noresp_err_seen", 64'(found), 64'd1);
        check("noresp_err_time", 64'(err_cyc - rel_cyc), 64'd200);
        check("noresp_errcode", 64'(err_code), 64'd1);
        check("noresp_oe", 64'(dht_oe), 64'd0);
        check("noresp_busy", 64'(busy), 64'd0);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        check("start_in_err_ignored", 64'(busy), 64'd0);

        // Line stuck high at bit 17, restart the cycle after the err pulse
        do_start();
        measure_oe(n_hi, rel_cyc);
        send_bits(F_GOOD, 17, -1);
        finish_frame(fall_cyc);
        wait_err(400, found, err_cyc);
        check("stuck_err_seen", 64'(found), 64'd1);
        check("stuck_errcode", 64'(err_code), 64'd1);
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        check("restart_busy", 64'(busy), 64'd1);
        check("restart_errcode_clr", 64'(err_code), 64'd0);
        measure_oe(n_hi, rel_cyc);
        send_bits(F_GOOD, 40, -1);
        finish_frame(fall_cyc);
        check("restart_validcnt", 64'(valid_cnt), 64'd2);
        check("errcnt_total", 64'(err_cnt), 64'd3);

        // start pulses during START_LOW and BIT_HIGH are ignored
        do_start();
        repeat (30) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        measure_oe(n_hi, rel_cyc);
        check("ign_start_low_len", 64'(n_hi), 64'd69);
        send_bits(F_ALT, 40, 10);
        finish_frame(fall_cyc);
        check("ign_validcnt", 64'(valid_cnt), 64'd3);
        check("alt_hum", 64'(humidity), 64'h0272);
        check("alt_temp", 64'(temperature), 64'h00FA);
        repeat (20) @(negedge clk);
        check("ign_no_second_frame", 64'({busy, dht_oe}), 64'd0);

        // Reset during bit 20
        do_start();
        measure_oe(n_hi, rel_cyc);
        send_bits(F_GOOD, 20, -1);
        dht_in = 1'b0;
        repeat (10) @(posedge clk); #1;
        check("mid_busy", 64'(busy), 64'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        dht_in = 1'b1;
        @(negedge clk);
        check("midrst_ctl", 64'({dht_oe, busy, valid, err, err_code}), 64'd0);
        check("midrst_hum", 64'(humidity), 64'd0);
        check("midrst_raw", 64'(raw), 64'd0);
        @(posedge clk); #1;
        do_start();
        measure_oe(n_hi, rel_cyc);
        check("post_rst_oe_len", 64'(n_hi), 64'd100);
        send_bits(F_GOOD, 40, -1);
        finish_frame(fall_cyc);
        check("post_rst_validcnt", 64'(valid_cnt), 64'd4);
        check("post_rst_raw", 64'(raw), 64'h35_0018_004D);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
